// File: rtl/demux_fifo_n_if.sv
// Bus bundle for demux_fifo_n: input word/selector handshake plus per-channel drain side.
// Carries drop_cnt only when DEMUX_DROP_CNT_EN is defined.
interface demux_fifo_n_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
);
    logic [DATA_W-1:0]        data_in;
    logic                     valid_in;
    logic [SEL_W-1:0]         selector;
    logic                     in_ready;
    logic [NUM_CH-1:0]        pop;
    logic [NUM_CH*DATA_W-1:0] data_out;
    logic [NUM_CH-1:0]        valid_out;
    logic [NUM_CH-1:0]        almost_full;
    logic                     error;
`ifdef DEMUX_DROP_CNT_EN
    logic [7:0]               drop_cnt;

    modport master (
        output data_in, valid_in, selector, pop,
        input  in_ready, data_out, valid_out, almost_full, error, drop_cnt
    );
    modport slave (
        input  data_in, valid_in, selector, pop,
        output in_ready, data_out, valid_out, almost_full, error, drop_cnt
    );
`else
    modport master (
        output data_in, valid_in, selector, pop,
        input  in_ready, data_out, valid_out, almost_full, error
    );
    modport slave (
        input  data_in, valid_in, selector, pop,
        output in_ready, data_out, valid_out, almost_full, error
    );
`endif
endinterface

// File: rtl/demux_fifo_n.sv
// 1-to-NUM_CH demultiplexer with an independent show-ahead FIFO per channel.
// Optional saturating drop counter enabled by defining DEMUX_DROP_CNT_EN.
module demux_fifo_n #(
    parameter int DATA_W   = 8,
    parameter int NUM_CH   = 4,
    parameter int SEL_W    = 2,
    parameter int FIFO_AW  = 2,
    parameter int AF_LEVEL = 3
) (
    input  logic           clk,
    input  logic           reset,
    demux_fifo_n_if.slave  bus
);
    localparam int CW = FIFO_AW + 1;
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [CW-1:0]      DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]      AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0]      CNT_ONE = CW'(1);
    localparam logic [CW-1:0]      CNT_ZERO = CW'(0);
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
    localparam logic [FIFO_AW-1:0] PTR_ZERO = FIFO_AW'(0);

    logic [CW-1:0]      count_q  [NUM_CH];
    logic [CW-1:0]      count_d  [NUM_CH];
    logic [FIFO_AW-1:0] wr_ptr_q [NUM_CH];
    logic [FIFO_AW-1:0] wr_ptr_d [NUM_CH];
    logic [FIFO_AW-1:0] rd_ptr_q [NUM_CH];
    logic [FIFO_AW-1:0] rd_ptr_d [NUM_CH];
    logic [DATA_W-1:0]  mem_q    [NUM_CH][DEPTH];
    logic [NUM_CH-1:0]  push_s;
    logic [NUM_CH-1:0]  pop_s;
    logic               in_ready_s;
    logic               error_d;
    logic               error_q;
`ifdef DEMUX_DROP_CNT_EN
    logic [7:0]         drop_cnt_q;
`endif

    // Route the input word and compute next pointer/count state for every channel.
    always_comb begin
        in_ready_s = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            in_ready_s = (int'(bus.selector) == k) ? (count_q[k] != DEPTH_C) : in_ready_s;
        end
        error_d = bus.valid_in && !in_ready_s;
        for (int k = 0; k < NUM_CH; k++) begin
            push_s[k]   = bus.valid_in && in_ready_s && (int'(bus.selector) == k);
            pop_s[k]    = bus.pop[k] && (count_q[k] != CNT_ZERO);
            wr_ptr_d[k] = push_s[k] ? (wr_ptr_q[k] + PTR_ONE) : wr_ptr_q[k];
            rd_ptr_d[k] = pop_s[k]  ? (rd_ptr_q[k] + PTR_ONE) : rd_ptr_q[k];
            case ({push_s[k], pop_s[k]})
                2'b10:   count_d[k] = count_q[k] + CNT_ONE;
                2'b01:   count_d[k] = count_q[k] - CNT_ONE;
                default: count_d[k] = count_q[k];
            endcase
        end
    end

    // Pointer, count and error state; reset discards all buffered words at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                count_q[k]  <= CNT_ZERO;
                wr_ptr_q[k] <= PTR_ZERO;
                rd_ptr_q[k] <= PTR_ZERO;
            end
            error_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                count_q[k]  <= count_d[k];
                wr_ptr_q[k] <= wr_ptr_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
            end
            error_q <= error_d;
        end
    end

    // FIFO storage; never read while the channel is empty, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (push_s[k]) begin
                mem_q[k][wr_ptr_q[k]] <= bus.data_in;
            end
        end
    end

`ifdef DEMUX_DROP_CNT_EN
    // Saturating count of dropped words, stepped alongside the error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= 8'd0;
        end else if (error_d && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end else begin
            drop_cnt_q <= drop_cnt_q;
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
`endif

    // Show-ahead outputs derived purely from registered state.
    always_comb begin
        bus.data_out    = {(NUM_CH*DATA_W){1'b0}};
        bus.valid_out   = {NUM_CH{1'b0}};
        bus.almost_full = {NUM_CH{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            bus.valid_out[k]   = (count_q[k] != CNT_ZERO);
            bus.almost_full[k] = (count_q[k] >= AF_C);
            bus.data_out[k*DATA_W +: DATA_W] = bus.valid_out[k] ? mem_q[k][rd_ptr_q[k]]
                                                                : {DATA_W{1'b0}};
        end
    end

    assign bus.in_ready = in_ready_s;
    assign bus.error    = error_q;

endmodule

// File: tb/tb_demux_fifo_n.sv
// Directed scoreboard bench for demux_fifo_n (4-channel instance plus a 3-channel instance
// for the out-of-range selector case).
module tb_demux_fifo_n;
    typedef logic [7:0] q_t [$];

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    q_t   sb [4];
    logic err_exp;

    always #5 clk = ~clk;

    demux_fifo_n_if #(.DATA_W(8), .NUM_CH(4), .SEL_W(2)) bus_a ();
    demux_fifo_n_if #(.DATA_W(8), .NUM_CH(3), .SEL_W(2)) bus_b ();

    demux_fifo_n #(.DATA_W(8), .NUM_CH(4), .SEL_W(2), .FIFO_AW(2), .AF_LEVEL(3)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave)
    );
    demux_fifo_n #(.DATA_W(8), .NUM_CH(3), .SEL_W(2), .FIFO_AW(2), .AF_LEVEL(3)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [3:0] v;
        logic [3:0] af;
        for (int k = 0; k < 4; k++) begin
            v[k]  = (sb[k].size() != 0);
            af[k] = (sb[k].size() >= 3);
        end
        chk("valid_out", {28'd0, bus_a.valid_out}, {28'd0, v});
        chk("almost_full", {28'd0, bus_a.almost_full}, {28'd0, af});
        chk("error", {31'd0, bus_a.error}, {31'd0, err_exp});
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("data_out%0d", k), {24'd0, bus_a.data_out[k*8 +: 8]},
                {24'd0, (v[k] ? sb[k][0] : 8'h00)});
        end
    endtask

    task automatic step(input logic vld, input logic [1:0] sel, input logic [7:0] d,
                        input logic [3:0] pm);
        logic rdy;
        bus_a.valid_in = vld;
        bus_a.selector = sel;
        bus_a.data_in  = d;
        bus_a.pop      = pm;
        #1;
        rdy = (sb[sel].size() < 4);
        chk("in_ready", {31'd0, bus_a.in_ready}, {31'd0, rdy});
        for (int k = 0; k < 4; k++) begin
            if (pm[k] && (sb[k].size() != 0)) void'(sb[k].pop_front());
        end
        if (vld && rdy) sb[sel].push_back(d);
        err_exp = vld && !rdy;
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        reset          = 1'b1;
        err_exp        = 1'b0;
        bus_a.valid_in = 1'b0;
        bus_a.selector = 2'd0;
        bus_a.data_in  = 8'h00;
        bus_a.pop      = 4'b0000;
        bus_b.valid_in = 1'b0;
        bus_b.selector = 2'd0;
        bus_b.data_in  = 8'h00;
        bus_b.pop      = 3'b000;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;

        // Three words to channel 2, then drain
        step(1'b1, 2'd2, 8'hA1, 4'b0000);
        step(1'b1, 2'd2, 8'hB2, 4'b0000);
        step(1'b1, 2'd2, 8'hC3, 4'b0000);
        step(1'b0, 2'd0, 8'h00, 4'b0100);
        step(1'b0, 2'd0, 8'h00, 4'b0100);
        step(1'b0, 2'd0, 8'h00, 4'b0100);
        step(1'b0, 2'd0, 8'h00, 4'b0100);

        // Fill channel 1, drop, then push+pop on full channel, then drain
        for (int i = 0; i < 4; i++) step(1'b1, 2'd1, 8'h10 + 8'(i), 4'b0000);
        step(1'b1, 2'd1, 8'h55, 4'b0000);
`ifdef DEMUX_DROP_CNT_EN
        chk("drop_cnt", {24'd0, bus_a.drop_cnt}, 32'd1);
`endif
        step(1'b0, 2'd0, 8'h00, 4'b0000);
        step(1'b1, 2'd1, 8'h66, 4'b0010);
        for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 8'h00, 4'b0010);

        // Out-of-range selector on the 3-channel instance
        bus_b.valid_in = 1'b1;
        bus_b.selector = 2'd3;
        bus_b.data_in  = 8'h77;
        #1;
        chk("b_in_ready", {31'd0, bus_b.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("b_error_pulse", {31'd0, bus_b.error}, 32'd1);
        chk("b_valid_out", {29'd0, bus_b.valid_out}, 32'd0);
        bus_b.valid_in = 1'b0;
        @(posedge clk);
        #1;
        chk("b_error_clear", {31'd0, bus_b.error}, 32'd0);
        chk("b_valid_out2", {29'd0, bus_b.valid_out}, 32'd0);

        // Continuous push/pop on channel 0 with wrapping pointers
        step(1'b1, 2'd0, 8'h00, 4'b0000);
        step(1'b1, 2'd0, 8'h01, 4'b0000);
        for (int i = 2; i < 10; i++) step(1'b1, 2'd0, 8'(i), 4'b0001);
        step(1'b0, 2'd0, 8'h00, 4'b0001);
        step(1'b0, 2'd0, 8'h00, 4'b0001);

        // Simultaneous pops on two channels
        step(1'b1, 2'd0, 8'h31, 4'b0000);
        step(1'b1, 2'd3, 8'h3C, 4'b0000);
        step(1'b0, 2'd0, 8'h00, 4'b1001);

        // Load channels 0 and 3, leave an error pulse pending, then reset mid-cycle
        step(1'b1, 2'd0, 8'h40, 4'b0000);
        for (int i = 0; i < 4; i++) step(1'b1, 2'd3, 8'h41 + 8'(i), 4'b0000);
        step(1'b1, 2'd3, 8'h45, 4'b0000);
        bus_a.valid_in = 1'b0;
        bus_a.pop      = 4'b0000;
        #2;
        reset = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) sb[k].delete();
        err_exp = 1'b0;
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 2'd3, 8'h7E, 4'b0000);
        step(1'b0, 2'd0, 8'h00, 4'b1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/demux_fifo_n.md
Name: demux_fifo_n

Overview:
- Parametrised 1-to-NUM_CH demultiplexer with an independent show-ahead FIFO on every output channel.
- Routes one DATA_W-bit word per cycle from a single valid-qualified input to the channel chosen by selector.
- Buffers up to FIFO_DEPTH words per channel; each consumer drains its channel with its own pop strobe.
- Sits between the byte-stream source and multiple lane consumers. It is the multi-channel, back-pressured successor of the 2-channel registered demux.

Parameters:
- DATA_W, 8, width of data word
- NUM_CH, 4, number of output channels (2..16)
- SEL_W, 2, selector width; must satisfy 2**SEL_W >= NUM_CH
- FIFO_AW, 2, per-channel FIFO address width; FIFO_DEPTH = 2**FIFO_AW
- AF_LEVEL, 3, per-channel occupancy at or above which almost_full asserts (1..FIFO_DEPTH)

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- data_in  input  DATA_W  input word
- valid_in  input  1  data_in valid this cycle
- selector  input  SEL_W  destination channel index
- in_ready  output  1  selected channel can accept a word (combinational)
- pop  input  NUM_CH  per-channel read strobe
- data_out  output  NUM_CH*DATA_W  head word of each channel; channel k occupies bits [k*DATA_W +: DATA_W]
- valid_out  output  NUM_CH  channel k FIFO is non-empty
- almost_full  output  NUM_CH  channel k occupancy >= AF_LEVEL
- error  output  1  one-cycle pulse: an input word was dropped

Behaviour:
- Reset is asynchronous and active-high. While reset is high:
  - all read/write pointers and counts are 0
  - valid_out = 0, almost_full = 0, error = 0
  - data_out = 0
  - FIFO storage need not be cleared
  - a reset mid-operation discards all buffered words immediately, without waiting for a clock edge
- Per-channel count is FIFO_AW+1 bits wide, range 0..FIFO_DEPTH.
- Pointers are FIFO_AW bits and wrap modulo FIFO_DEPTH.
- in_ready is combinational: 1 when selector < NUM_CH and count[selector] < FIFO_DEPTH, else 0.
  - It is based on the registered count only; a same-cycle pop does not raise it.
- Push: when valid_in && in_ready, at the clock edge data_in is written to FIFO[selector] and that channel's write pointer and count advance.
- Drop: when valid_in && !in_ready, the word is discarded, no state changes, and error is 1 for the next cycle only.
  - This covers both selector >= NUM_CH and a full target channel.
- Pop: when pop[k] && valid_out[k], channel k's read pointer advances and its count decrements.
  - pop[k] while the channel is empty is ignored and is not an error.
- Simultaneous push and pop on the same non-full channel: both take effect and the count is unchanged.
  - On a full channel, the push is dropped (error) and the pop proceeds.
- Show-ahead output: data_out[k] always presents FIFO[k][rd_ptr] when valid_out[k] = 1, and is forced to 0 when the channel is empty.
- Latency: a word pushed at edge N is visible on data_out/valid_out in the cycle after edge N (1-cycle latency).
  - After a pop at edge M, the next word (or 0/invalid) is presented after edge M.
- valid_out, almost_full and error are registered or derived only from registered state; there are no combinational paths from pop.
- Channels are fully independent; pops on several channels in the same cycle are all honoured.
- valid_in = 0 means no write regardless of selector.

Optional Feature:
- Macro: DEMUX_DROP_CNT_EN
- Defined:
  - adds output port drop_cnt [7:0]
  - drop_cnt increments by 1 on every cycle in which error is set, and saturates at 255
  - reset clears it to 0
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset with defaults: assert reset asynchronously between edges -> valid_out=4'b0000, data_out=0, almost_full=0, and error=0 immediately.
- Push 0xA1, 0xB2, 0xC3 with selector=2, no pops:
  - valid_out=4'b0100 one cycle after the first push
  - data_out[2]=0xA1
  - almost_full[2]=1 after the third push
  - pop[2] three times yields 0xB2, then 0xC3, then valid_out[2]=0 with data_out[2]=0.
- Fill channel 1 with 4 words, then push 0x55 to channel 1 -> in_ready=0, word dropped, one-cycle error pulse, channel 1 contents unchanged.
  - With DEMUX_DROP_CNT_EN defined, drop_cnt=1.
- Selector=3 with NUM_CH=3 and valid_in=1 -> in_ready=0, error pulse, no channel changes.
- Continuous push and pop on channel 0 for 10 cycles with incrementing data 0x00..0x09 -> count stays constant, data emerges in order, and pointers wrap with no loss.
- Reset asserted while channels 0 and 3 hold data -> all valid_out clear immediately.
  - After reset release, a first push of 0x7E to channel 3 appears alone at the head.
